// File: rtl/btn_deb_pkg.sv
// rtl/btn_deb_pkg.sv - shared types and helpers for the multi-channel button conditioner
package btn_deb_pkg;

    typedef enum logic [1:0] {IDLE, HOLD, RPT} rpt_state_t;

    // Bits needed to hold any value in 0..n
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/btn_deb_chan.sv
// rtl/btn_deb_chan.sv - one button channel: synchroniser, stable-interval debounce, press/repeat FSM
module btn_deb_chan
    import btn_deb_pkg::*;
#(
    parameter int N_CYC_DEB   = 300_000,
    parameter int ACTIVE_HIGH = 1,
    parameter int REPEAT_EN   = 0,
    parameter int REPEAT_DLY  = 50_000_000,
    parameter int REPEAT_PER  = 10_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic lvl,
    output logic rise,
    output logic fall,
    output logic press
);

    localparam int DW   = cnt_width(N_CYC_DEB);
    localparam int RMAX = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
    localparam int RW   = cnt_width(RMAX);

    localparam logic [DW-1:0] DEB_LAST = DW'(N_CYC_DEB - 1);
    localparam logic [RW-1:0] DLY_LAST = RW'(REPEAT_DLY - 1);
    localparam logic [RW-1:0] PER_LAST = RW'(REPEAT_PER - 1);

    logic          norm;
    logic          meta;
    logic          sync;
    logic [DW-1:0] deb_cnt;
    logic          toggle;
    logic          rise_next;
    logic          fall_next;

    rpt_state_t    state;
    rpt_state_t    state_next;
    logic [RW-1:0] rpt_cnt;
    logic [RW-1:0] rpt_cnt_next;
    logic          press_next;

    assign norm = (ACTIVE_HIGH != 0) ? btn : ~btn;

    // The count saturates at N_CYC_DEB-1 and flips the level on the following disagreeing cycle
    assign toggle    = (sync != lvl) && (deb_cnt == DEB_LAST);
    assign rise_next = toggle & ~lvl;
    assign fall_next = toggle & lvl;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta    <= 1'b0;
            sync    <= 1'b0;
            deb_cnt <= '0;
            lvl     <= 1'b0;
            rise    <= 1'b0;
            fall    <= 1'b0;
        end else begin
            meta <= norm;
            sync <= meta;
            if (sync == lvl || toggle) begin
                deb_cnt <= '0;
            end else begin
                deb_cnt <= deb_cnt + 1'b1;
            end
            lvl  <= lvl ^ toggle;
            rise <= rise_next;
            fall <= fall_next;
        end
    end

    always_comb begin
        state_next   = state;
        rpt_cnt_next = rpt_cnt;
        press_next   = 1'b0;
        if (fall_next) begin
            state_next   = IDLE;
            rpt_cnt_next = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (rise_next) begin
                        state_next   = HOLD;
                        rpt_cnt_next = '0;
                        press_next   = 1'b1;
                    end
                end
                HOLD: begin
                    if (REPEAT_EN != 0) begin
                        if (rpt_cnt == DLY_LAST) begin
                            state_next   = RPT;
                            rpt_cnt_next = '0;
                            press_next   = 1'b1;
                        end else begin
                            rpt_cnt_next = rpt_cnt + 1'b1;
                        end
                    end
                end
                RPT: begin
                    if (rpt_cnt == PER_LAST) begin
                        rpt_cnt_next = '0;
                        press_next   = 1'b1;
                    end else begin
                        rpt_cnt_next = rpt_cnt + 1'b1;
                    end
                end
                default: begin
                    state_next   = IDLE;
                    rpt_cnt_next = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            rpt_cnt <= '0;
            press   <= 1'b0;
        end else begin
            state   <= state_next;
            rpt_cnt <= rpt_cnt_next;
            press   <= press_next;
        end
    end

endmodule

// File: rtl/btn_debounce_multi.sv
// rtl/btn_debounce_multi.sv - N independent debounced pushbutton channels with rise/fall/press outputs
module btn_debounce_multi
    import btn_deb_pkg::*;
#(
    parameter int N_BTN       = 5,
    parameter int N_CYC_DEB   = 300_000,
    parameter int ACTIVE_HIGH = 1,
    parameter int REPEAT_EN   = 0,
    parameter int REPEAT_DLY  = 50_000_000,
    parameter int REPEAT_PER  = 10_000_000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_BTN-1:0] btn_in,
    output logic [N_BTN-1:0] btn_lvl,
    output logic [N_BTN-1:0] btn_rise,
    output logic [N_BTN-1:0] btn_fall,
    output logic [N_BTN-1:0] btn_press
);

    for (genvar i = 0; i < N_BTN; i++) begin : g_chan
        btn_deb_chan #(
            .N_CYC_DEB   (N_CYC_DEB),
            .ACTIVE_HIGH (ACTIVE_HIGH),
            .REPEAT_EN   (REPEAT_EN),
            .REPEAT_DLY  (REPEAT_DLY),
            .REPEAT_PER  (REPEAT_PER)
        ) u_chan (
            .clk   (clk),
            .rst_n (rst_n),
            .btn   (btn_in[i]),
            .lvl   (btn_lvl[i]),
            .rise  (btn_rise[i]),
            .fall  (btn_fall[i]),
            .press (btn_press[i])
        );
    end

endmodule

// File: tb/tb_btn_debounce_multi.sv
// tb/tb_btn_debounce_multi.sv - scoreboard bench for btn_debounce_multi against a window/timestamp reference model
module tb_btn_debounce_multi;

    localparam int ND = 4;
    localparam int RD = 10;
    localparam int RP = 3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] btn_a, btn_b;
    logic [1:0] lvl_a, rise_a, fall_a, press_a;
    logic [1:0] lvl_b, rise_b, fall_b, press_b;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int e0, rel;

    logic [15:0] exp_q[$];

    bit [7:0] hist  [2][2];
    bit       mlvl  [2][2];
    int       since [2][2];

    always #5 clk = ~clk;

    // Active-high input, auto-repeat enabled
    btn_debounce_multi #(
        .N_BTN(2), .N_CYC_DEB(ND), .ACTIVE_HIGH(1), .REPEAT_EN(1),
        .REPEAT_DLY(RD), .REPEAT_PER(RP)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .btn_in(btn_a),
        .btn_lvl(lvl_a), .btn_rise(rise_a), .btn_fall(fall_a), .btn_press(press_a)
    );

    // Active-low input, auto-repeat disabled
    btn_debounce_multi #(
        .N_BTN(2), .N_CYC_DEB(ND), .ACTIVE_HIGH(0), .REPEAT_EN(0),
        .REPEAT_DLY(RD), .REPEAT_PER(RP)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .btn_in(btn_b),
        .btn_lvl(lvl_b), .btn_rise(rise_b), .btn_fall(fall_b), .btn_press(press_b)
    );

    // Reference: level flips once the last N samples seen through the synchroniser all disagree with it;
    // presses are timestamped from the rise.
    always @(posedge clk) begin
        logic [1:0] ml [2];
        logic [1:0] mr [2];
        logic [1:0] mf [2];
        logic [1:0] mp [2];
        bit raw, s, tog;
        cyc++;
        for (int d = 0; d < 2; d++) begin
            ml[d] = '0; mr[d] = '0; mf[d] = '0; mp[d] = '0;
            for (int c = 0; c < 2; c++) begin
                raw = (d == 0) ? btn_a[c] : btn_b[c];
                if (!rst_n) begin
                    hist[d][c]  = '0;
                    mlvl[d][c]  = 1'b0;
                    since[d][c] = -1;
                end else begin
                    s = (d == 0) ? raw : !raw;
                    hist[d][c] = {hist[d][c][6:0], s};
                    tog = 1'b1;
                    for (int j = 2; j <= ND + 1; j++) begin
                        if (hist[d][c][j] == mlvl[d][c]) tog = 1'b0;
                    end
                    if (tog && !mlvl[d][c]) begin
                        mr[d][c] = 1'b1;
                        mp[d][c] = 1'b1;
                        since[d][c] = 0;
                    end else if (tog) begin
                        mf[d][c] = 1'b1;
                        since[d][c] = -1;
                    end else if (since[d][c] >= 0) begin
                        since[d][c]++;
                        if (d == 0 && since[d][c] >= RD && (since[d][c] - RD) % RP == 0)
                            mp[d][c] = 1'b1;
                    end
                    if (tog) mlvl[d][c] = !mlvl[d][c];
                    ml[d][c] = mlvl[d][c];
                end
            end
        end
        exp_q.push_back({ml[0], mr[0], mf[0], mp[0], ml[1], mr[1], mf[1], mp[1]});
    end

    always @(negedge clk) begin
        logic [15:0] e;
        logic [15:0] act;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            if (!rst_n) e = '0;
            act = {lvl_a, rise_a, fall_a, press_a, lvl_b, rise_b, fall_b, press_b};
            total++;
            if (act !== e) begin
                bad++;
                $display("FAIL scoreboard cyc=%0d actual=%h expected=%h", cyc, act, e);
            end
        end
    end

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d actual=%0h expected=%0h", name, cyc, act, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        btn_a = 2'b00;
        btn_b = 2'b11;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (4) @(posedge clk);

        // Held press with repeats on dut_a ch0; simultaneous active-low press on both dut_b channels
        #1 e0 = cyc; btn_a = 2'b01; btn_b = 2'b00;
        for (int i = 0; i < 24; i++) begin
            @(negedge clk); rel = cyc - e0;
            chk("rpt_press", 8'(press_a[0]), 8'(rel == 6 || rel == 16 || rel == 19 || rel == 22));
            chk("both_rise", 8'(rise_b), (rel == 6) ? 8'd3 : 8'd0);
            chk("ch1_quiet", 8'(lvl_a[1]), 8'd0);
        end

        // Release: repeats continue until the debounced fall, then stop
        @(posedge clk); #1 e0 = cyc; btn_a = 2'b00; btn_b = 2'b11;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk); rel = cyc - e0;
            chk("rel_press", 8'(press_a[0]), 8'(rel == 1 || rel == 4));
            chk("rel_fall", 8'(fall_a[0]), 8'(rel == 6));
            chk("rel_fall_b", 8'(fall_b), (rel == 6) ? 8'd3 : 8'd0);
        end

        // Bounce on ch1: high 3, low 1, then steady high
        for (int i = 0; i < 14; i++) begin
            @(posedge clk); #1;
            if (i == 0) e0 = cyc;
            btn_a[1] = (i == 3) ? 1'b0 : 1'b1;
            @(negedge clk); rel = cyc - e0;
            chk("bounce_lvl", 8'(lvl_a[1]), 8'(rel >= 10));
            chk("bounce_rise", 8'(rise_a[1]), 8'(rel == 10));
        end
        @(posedge clk); #1 btn_a[1] = 1'b0;
        repeat (12) @(posedge clk);

        // Reset in mid-count discards the partial count
        #1 btn_a[0] = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        #1 chk("rst_mid_outputs", {lvl_a, rise_a, press_a, lvl_b}, 8'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1; e0 = cyc;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk); rel = cyc - e0;
            chk("post_rst_rise", 8'(rise_a[0]), 8'(rel == 6));
            chk("post_rst_lvl", 8'(lvl_a[0]), 8'(rel >= 6));
        end

        // Reset clears a settled pressed level without waiting for a clock edge
        @(posedge clk); #1 rst_n = 1'b0;
        #1 chk("rst_async_lvl", 8'(lvl_a[0]), 8'd0);
        @(posedge clk); #1 rst_n = 1'b1; btn_a = 2'b00;
        repeat (10) @(posedge clk);

        // Random glitches, holds and occasional resets
        for (int i = 0; i < 4000; i++) begin
            @(posedge clk); #1;
            rst_n = ($urandom_range(699) != 0);
            if ($urandom_range(6) == 0) btn_a = 2'($urandom);
            if ($urandom_range(6) == 0) btn_b = 2'($urandom);
            if ($urandom_range(40) == 0) begin
                btn_a = 2'($urandom);
                btn_b = 2'($urandom);
                repeat (30) @(posedge clk);
                #1;
            end
        end
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/btn_debounce_multi.md
# btn_debounce_multi

Parametrised multi-channel pushbutton conditioner, successor to the single-button rising-edge counter. Each channel is synchronised, then debounced with a stable-interval counter. Each channel produces a clean level, one-cycle rise/fall pulses, and an optional hold-to-auto-repeat press pulse. Sits between the board pushbutton pins and the control FSMs.

## Interface
- N_BTN, 5: number of independent channels (≥1).
- N_CYC_DEB, 300_000: consecutive stable cycles required to accept a new level (≥2).
- ACTIVE_HIGH, 1: 1 means a raw 1 is pressed; 0 means raw inputs are inverted before debouncing.
- REPEAT_EN, 0: 1 enables auto-repeat on `btn_press`.
- REPEAT_DLY, 50_000_000: hold cycles from the initial press pulse to the first repeat (≥2).
- REPEAT_PER, 10_000_000: cycles between subsequent repeats (≥2).

Ports:
- clk  in  1  single clock; all logic is on its rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- btn_in  in  N_BTN  raw asynchronous button pins.
- btn_lvl  out  N_BTN  debounced pressed level.
- btn_rise  out  N_BTN  one-cycle pulse when `btn_lvl` goes 0→1.
- btn_fall  out  N_BTN  one-cycle pulse when `btn_lvl` goes 1→0.
- btn_press  out  N_BTN  one-cycle press pulse, plus repeats while held if REPEAT_EN=1.

## Operation
- **Polarity:** each channel normalises its input to pressed=1 using ACTIVE_HIGH.
- **Synchroniser:** 2-flop synchroniser per channel. Reset value is the released level, so no edge appears after reset.
- **Debounce:**
  - When `sync` ≠ `btn_lvl`: the counter increments.
  - When `sync` = `btn_lvl`: the counter clears to 0.
  - When the counter would reach N_CYC_DEB: `btn_lvl` toggles and the counter clears.
  - Any glitch shorter than N_CYC_DEB cycles produces no output change.
  - Counter width is $clog2(N_CYC_DEB+1) bits. The counter never wraps.
- **Pulses:** `btn_rise` and `btn_fall` are registered and asserted in the same cycle the new `btn_lvl` value first appears.
- **Repeat FSM** (per channel), states IDLE, HOLD, RPT:
  - IDLE → HOLD on rise. `btn_press` pulses in that same cycle and the repeat counter clears.
  - HOLD: when the counter reaches REPEAT_DLY-1, `btn_press` pulses and the FSM goes to RPT with the counter cleared.
  - RPT: `btn_press` pulses every REPEAT_PER cycles.
  - From any state, fall → IDLE, counter cleared, no pulse.
  - With REPEAT_EN=0 the FSM stays IDLE/HOLD only and `btn_press` equals `btn_rise`.
- **Channels:** fully independent. Simultaneous events on different channels are all reported in the same cycle.

## Timing
- **Reset:** while rst_n=0, every output is 0 and all counters and FSMs are cleared (IDLE). This applies immediately and asynchronously. Reset in mid-count discards the partial count.
- **Press latency:** a raw change stable from edge k gives `btn_lvl` and `btn_rise` at edge k+N_CYC_DEB+2. Release latency is identical.
- **Repeats:** first repeat at rise+REPEAT_DLY cycles, then every REPEAT_PER cycles.
- **Pulse width:** every pulse output is high for exactly 1 cycle. `btn_rise` and `btn_fall` are never both high on one channel.

## Structure
- Package `btn_deb_pkg` holds:
  - `typedef enum logic [1:0] {IDLE, HOLD, RPT} rpt_state_t`;
  - the counter-width helper function.
- Sub-module `btn_deb_chan` implements one channel (sync, debounce, FSM), with the same parameters minus N_BTN.
- The top generates N_BTN instances of `btn_deb_chan`.

## Test plan
All scenarios use N_BTN=2, N_CYC_DEB=4, REPEAT_DLY=10, REPEAT_PER=3, with `btn_in` driven on clock edges.

1. **Clean press:** ch0 raised at edge 0 and held, REPEAT_EN=0 → `btn_lvl[0]` and `btn_rise[0]`/`btn_press[0]` at edge 6, pulse 1 cycle. Ch1 stays 0.
2. **Bounce:** ch0 high 3 cycles, low 1, then high steady from edge 4 → no output until edge 10. Exactly one rise pulse.
3. **Release:** after scenario 1, drop ch0 at edge 20 → `btn_fall[0]` and `btn_lvl[0]`=0 at edge 26.
4. **Auto-repeat:** REPEAT_EN=1, hold ch0 from edge 0 → `btn_press[0]` at edges 6, 16, 19, 22. Release stops further pulses and the FSM returns to IDLE.
5. **Polarity and simultaneity:** ACTIVE_HIGH=0, both raw inputs idle at 1 and driven to 0 at edge 0 → both `btn_rise` bits at edge 6 in the same cycle. No spurious pulse after reset.
6. **Reset mid-count:** assert rst_n=0 at edge 3 of a press for 2 cycles → outputs 0 immediately. After release from reset with the input still held, rise arrives N_CYC_DEB+2 cycles later.
